// File: rtl/tlc_pkg.sv
// Purpose: shared lamp codes, controller state encoding and timer width for the traffic-light controller.
// Latency: n/a (declarations only).
// Backpressure: n/a. Macro TLC_PED_EN adds the pedestrian walk state to the enum.
package tlc_pkg;

  localparam int TMR_W = 8;
  typedef logic [TMR_W-1:0] tmr_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  typedef enum logic [2:0] {
    ST_HWY_G,
    ST_HWY_Y,
    ST_ALLR1,
    ST_CNT_G,
    ST_CNT_Y,
    ST_ALLR2
`ifdef TLC_PED_EN
    , ST_PED_W
`endif
  } state_t;

endpackage

// File: rtl/tlc_phase_timer.sv
// Purpose: per-phase cycle counter; cleared on phase entry, counts while enabled.
// Latency: count reflects clear/enable one cycle after they are applied.
// Backpressure: none; enable is held low by the owner to saturate.
module tlc_phase_timer
  import tlc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output tmr_t count
);

  tmr_t count_q, count_d;

  // Next count: clear takes priority over counting
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tlc_phase_arb.sv
// Purpose: highway/country traffic-light phase sequencer with optional pedestrian walk (macro TLC_PED_EN).
// Latency: lamp outputs are registered and change on the same edge as the state register.
// Backpressure: none; vehicle sensor and button are sampled every cycle, requests are never dropped.
module tlc_phase_arb
  import tlc_pkg::*;
#(
`ifdef TLC_PED_EN
  parameter int unsigned WALK_TIME   = 6,
`endif
  parameter int unsigned MIN_GREEN   = 8,
  parameter int unsigned MAX_GREEN   = 20,
  parameter int unsigned YEL_TIME    = 3,
  parameter int unsigned ALLRED_TIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
`ifdef TLC_PED_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       busy
);

  // Timer values on the last cycle of each phase
  localparam tmr_t MIN_LAST  = tmr_t'(MIN_GREEN - 1);
  localparam tmr_t MAX_LAST  = tmr_t'(MAX_GREEN - 1);
  localparam tmr_t YEL_LAST  = tmr_t'(YEL_TIME - 1);
  localparam tmr_t ALLR_LAST = tmr_t'(ALLRED_TIME - 1);

  state_t     state_q, state_d;
  state_t     post_clr;     // where an all-red clearance goes when country is not taken
  tmr_t       tmr;
  logic       tmr_clr, tmr_en;
  logic       ped_pend;
  logic [1:0] hwy_d, hwy_q, cntry_d, cntry_q;
  logic       busy_d, busy_q;

  // Timer restarts on every state change; saturates so a long highway hold cannot wrap
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (tmr != '1);

  tlc_phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .count  (tmr)
  );

`ifdef TLC_PED_EN
  localparam tmr_t WALK_LAST = tmr_t'(WALK_TIME - 1);

  logic ped_pend_q, ped_pend_d;
  logic walk_q;

  // Latch button presses; drop the request as the walk phase starts, re-arm on presses during it
  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    if ((state_d == ST_PED_W) && (state_q != ST_PED_W)) begin
      ped_pend_d = 1'b0;
    end
  end

  // Pending-request and walk lamp registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= (state_d == ST_PED_W);
    end
  end

  assign ped_pend = ped_pend_q;
  assign post_clr = ped_pend_q ? ST_PED_W : ST_HWY_G;
  assign walk     = walk_q;
`else
  assign ped_pend = 1'b0;
  assign post_clr = ST_HWY_G;
`endif

  // State register; reset abandons any phase immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HWY_G;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: phase exits evaluated from the current timer value
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HWY_G: if ((tmr >= MIN_LAST) && (x || ped_pend)) state_d = ST_HWY_Y;
      ST_HWY_Y: if (tmr == YEL_LAST)  state_d = ST_ALLR1;
      ST_ALLR1: if (tmr == ALLR_LAST) state_d = x ? ST_CNT_G : post_clr;
      ST_CNT_G: if (((tmr >= MIN_LAST) && !x) || (tmr == MAX_LAST)) state_d = ST_CNT_Y;
      ST_CNT_Y: if (tmr == YEL_LAST)  state_d = ST_ALLR2;
      ST_ALLR2: if (tmr == ALLR_LAST) state_d = post_clr;
`ifdef TLC_PED_EN
      ST_PED_W: if (tmr == WALK_LAST) state_d = ST_HWY_G;
`endif
      default:  state_d = ST_HWY_G;
    endcase
  end

  // Output decode of the upcoming state so registered lamps line up with the state register
  always_comb begin
    hwy_d   = LAMP_RED;
    cntry_d = LAMP_RED;
    busy_d  = 1'b1;
    case (state_d)
      ST_HWY_G: begin
        hwy_d  = LAMP_GREEN;
        busy_d = 1'b0;
      end
      ST_HWY_Y: hwy_d   = LAMP_YELLOW;
      ST_CNT_G: cntry_d = LAMP_GREEN;
      ST_CNT_Y: cntry_d = LAMP_YELLOW;
      default:  ;
    endcase
  end

  // Lamp and busy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hwy_q   <= LAMP_GREEN;
      cntry_q <= LAMP_RED;
      busy_q  <= 1'b0;
    end else begin
      hwy_q   <= hwy_d;
      cntry_q <= cntry_d;
      busy_q  <= busy_d;
    end
  end

  assign hwy   = hwy_q;
  assign cntry = cntry_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_tlc_phase_arb.sv
// Purpose: scoreboard bench for tlc_phase_arb with default timing parameters.
// Latency: expected lamp pattern per cycle queued ahead, popped and compared each cycle.
// Backpressure: none.
module tb_tlc_phase_arb;

  // Expected {hwy, cntry, walk, busy} per phase
  localparam logic [5:0] PH_HG = 6'b00_10_0_0;
  localparam logic [5:0] PH_HY = 6'b01_10_0_1;
  localparam logic [5:0] PH_AR = 6'b10_10_0_1;
  localparam logic [5:0] PH_CG = 6'b10_00_0_1;
  localparam logic [5:0] PH_CY = 6'b10_01_0_1;
`ifdef TLC_PED_EN
  localparam logic [5:0] PH_PW = 6'b10_10_1_1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic [1:0] hwy, cntry;
  logic       busy;
  logic       walk;
`ifdef TLC_PED_EN
  logic       ped_req;
`else
  assign walk = 1'b0;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  tlc_phase_arb dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
`ifdef TLC_PED_EN
    .ped_req (ped_req),
    .walk    (walk),
`endif
    .hwy     (hwy),
    .cntry   (cntry),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got hwy/cntry/walk/busy=%b, expected %b", tag, obs, want);
    end
  endtask

  task automatic push(input logic [5:0] ph, input int n);
    repeat (n) exp_q.push_back(ph);
  endtask

  // Reset 2 cycles, then drive x in [x_on, x_off), a one-cycle button press at ped_at
  // and a one-cycle reset at rst_at, comparing one queued entry per cycle.
  task automatic run(input string name, input int x_on, input int x_off,
                     input int ped_at, input int rst_at);
    int n;
    reset = 1'b1;
    x     = 1'b0;
`ifdef TLC_PED_EN
    ped_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      x     = (k >= x_on) && (k < x_off);
      reset = (k == rst_at);
`ifdef TLC_PED_EN
      ped_req = (k == ped_at);
`endif
      chk($sformatf("%s@%0d", name, k), {hwy, cntry, walk, busy}, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    x     = 1'b0;
`ifdef TLC_PED_EN
    ped_req = 1'b0;
`endif
  endtask

  initial begin
    // Idle highway: no demand, highway green forever
    push(PH_HG, 50);
    run("idle", 0, 0, -1, -1);

    // Continuous demand: min green, yellow, all-red, country max-out, back to highway
    push(PH_HG, 8); push(PH_HY, 3); push(PH_AR, 2); push(PH_CG, 20);
    push(PH_CY, 3); push(PH_AR, 2); push(PH_HG, 8); push(PH_HY, 3);
    run("xhold", 0, 1000, -1, -1);

    // Country gap-out when sensor clears after minimum green
    push(PH_HG, 8); push(PH_HY, 3); push(PH_AR, 2); push(PH_CG, 11);
    push(PH_CY, 3); push(PH_AR, 2); push(PH_HG, 10);
    run("gap", 0, 23, -1, -1);

    // Sensor drops during highway yellow: sequence completes, all-red returns to highway
    push(PH_HG, 8); push(PH_HY, 3); push(PH_AR, 2); push(PH_HG, 10);
    run("xdrop", 0, 9, -1, -1);

    // Late arrival after min green; country then held only for its minimum
    push(PH_HG, 21); push(PH_HY, 3); push(PH_AR, 2); push(PH_CG, 8);
    push(PH_CY, 3); push(PH_AR, 2); push(PH_HG, 5);
    run("late", 20, 26, -1, -1);

`ifdef TLC_PED_EN
    // Single button press, no vehicles: walk served after all-red, request cleared
    push(PH_HG, 8); push(PH_HY, 3); push(PH_AR, 2); push(PH_PW, 6); push(PH_HG, 10);
    run("ped", 0, 0, 2, -1);

    // Vehicle and button together: country first, walk after second all-red
    push(PH_HG, 8); push(PH_HY, 3); push(PH_AR, 2); push(PH_CG, 20);
    push(PH_CY, 3); push(PH_AR, 2); push(PH_PW, 6); push(PH_HG, 10);
    run("xped", 0, 33, 0, -1);
`endif

    // Reset during country green: immediate highway green, pending walk discarded
    push(PH_HG, 8); push(PH_HY, 3); push(PH_AR, 2); push(PH_CG, 6); push(PH_HG, 12);
    run("rstcg", 0, 18, 0, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlc_phase_arb.md
TLC_PHASE_ARB -- requirements
Module: tlc_phase_arb

Interface
REQ-001 Parameter MIN_GREEN, default 8, is the minimum highway/country green time in clk cycles.
REQ-002 Parameter MAX_GREEN, default 20, is the maximum country green time in cycles.
REQ-003 Parameter YEL_TIME, default 3, is the yellow duration in cycles.
REQ-004 Parameter ALLRED_TIME, default 2, is the all-red clearance duration in cycles.
REQ-005 Parameter WALK_TIME, default 6, is the pedestrian walk duration in cycles; present only with TLC_PED_EN.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 x  in  1  country-road vehicle sensor, level, 1 = vehicle waiting.
REQ-009 ped_req  in  1  pedestrian button, single-cycle or level; present only with TLC_PED_EN.
REQ-010 hwy  out  2  highway lamp code.
REQ-011 cntry  out  2  country lamp code.
REQ-012 walk  out  1  pedestrian walk lamp; present only with TLC_PED_EN.
REQ-013 busy  out  1  high in every state except HWY_G.

Function
REQ-014 Lamp codes: GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 shall never be driven.
REQ-015 States: HWY_G, HWY_Y, ALLR1, CNT_G, CNT_Y, ALLR2, PED_W (PED_W only with TLC_PED_EN).
REQ-016 Timer: cleared to 0 on every state entry, increments each cycle; a state's exit is evaluated combinationally and the new state is registered on the next edge.
REQ-017 HWY_G: hwy=GREEN, cntry=RED; exit to HWY_Y when timer >= MIN_GREEN-1 and (x or ped_pend); otherwise hold indefinitely.
REQ-018 HWY_Y: hwy=YELLOW, cntry=RED; exit to ALLR1 when timer == YEL_TIME-1 (exactly YEL_TIME cycles).
REQ-019 ALLR1: both RED; at timer == ALLRED_TIME-1 go to CNT_G if x=1, else PED_W if ped_pend, else HWY_G.
REQ-020 CNT_G: hwy=RED, cntry=GREEN; exit to CNT_Y when timer >= MIN_GREEN-1 and x=0, or when timer == MAX_GREEN-1 regardless of x.
REQ-021 CNT_Y: hwy=RED, cntry=YELLOW; exit to ALLR2 after exactly YEL_TIME cycles.
REQ-022 ALLR2: both RED; after ALLRED_TIME cycles go to PED_W if ped_pend, else HWY_G.
REQ-023 PED_W: both RED, walk=1; after WALK_TIME cycles go to HWY_G.
REQ-024 ped_pend sets on any cycle ped_req=1; clears on the cycle PED_W is entered; a ped_req during PED_W sets ped_pend for the next cycle of service.
REQ-025 If x and ped_pend are both set at ALLR1 exit, country is served first; ped_pend is retained and served at ALLR2.
REQ-026 x dropping during HWY_Y or ALLR1 shall not abort the sequence; ALLR1 then routes per REQ-019.
REQ-027 All outputs shall be registered, decoded from the state register; no output glitches.
REQ-028 Timer is 8 bits; all parameters shall be in range 1..255, with MIN_GREEN <= MAX_GREEN.

Reset
REQ-029 Reset shall force state=HWY_G, timer=0, ped_pend=0, hwy=GREEN, cntry=RED, walk=0, busy=0 on the next edge.
REQ-030 Reset asserted mid-sequence (any state) shall abandon the sequence immediately; there is no yellow run-out.

Configuration
REQ-031 Macro TLC_PED_EN: when defined, ped_req, walk, WALK_TIME, ped_pend and PED_W exist; when undefined they are absent, ped_pend is treated as 0, and ALLR1/ALLR2 never route to PED_W.

Structure
REQ-032 Package tlc_pkg shall hold the lamp-code constants, the state enum typedef and the timer width constant.
REQ-033 Sub-module tlc_phase_timer (clear, enable, 8-bit count) shall implement the timer.

Verification (defaults, TLC_PED_EN defined)
REQ-034 Reset for 2 cycles with x=0 for 50 cycles -> hwy=GREEN and cntry=RED throughout, busy=0.
REQ-035 x=1 from cycle 0 after reset -> HWY_G lasts 8 cycles, HWY_Y 3, ALLR1 2, then cntry=GREEN.
REQ-036 x held at 1 -> CNT_G lasts exactly 20 cycles, then CNT_Y 3, ALLR2 2, HWY_G.
REQ-037 Single-cycle ped_req pulse with x=0 -> HWY_Y, ALLR1, walk=1 for 6 cycles, then HWY_G with walk=0.
REQ-038 x=1 and a ped_req pulse in the same cycle -> country phase first, then PED_W after ALLR2.
REQ-039 Reset asserted during CNT_G -> the next cycle shows hwy=GREEN, cntry=RED, walk=0 and ped_pend cleared.
